stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Button front-end and run/stop/clear sequencer for the stopwatch time base and display selector. It takes three raw push-buttons and synchronises and debounces each one. It then detects presses and runs a small FSM that drives the counter's enable/clear inputs and the display's change input. It sits between the board buttons and the time-select datapath, and all outputs are in the 100 MHz clk domain.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable clk cycles needed to accept a button level change (10 ms at 100 MHz); legal minimum 1; benches override with 4.

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-high reset
btn_run_stop  input  1  raw button, asynchronous, active-high; toggles run/stop
btn_clear  input  1  raw button, asynchronous, active-high; clears counters while stopped
btn_mode  input  1  raw button, asynchronous, active-high; toggles display SEC_MSEC/HOUR_MIN
enable  output  1  counter run enable; high while in RUN
clear  output  1  one-cycle counter clear pulse
change  output  1  one-cycle display-mode toggle pulse
state  output  2  FSM state for debug/LED: 00 STOP, 01 RUN, 10 CLEAR

Behaviour:
- One clock; reset is synchronous and active-high. Sampled on the rising edge of clk, it clears the following:
  - all synchroniser FFs, debounce counters and stable levels to 0
  - state to STOP
  - enable, clear and change to 0
- Reset mid-operation:
  - aborts any debounce in progress; no pulse is emitted for it.
  - a button held through reset counts as a new press once its debounce completes after reset deasserts.
- Per-button pipeline (three identical channels):
  - 2-FF synchroniser.
  - Debounce: a counter increments each cycle the synced level differs from the stable level. It resets to 0 on any cycle where they match. When the counter would reach DEBOUNCE_CYCLES, the stable level takes the synced level and the counter resets.
  - Press detect: press is a 1-cycle pulse, asserted in the cycle after the stable level goes 0->1.
  - Releases are debounced identically and produce no pulse.
  - Bounce shorter than DEBOUNCE_CYCLES produces no press.
  - A held button produces exactly one press.
- Latency: from the first clk edge sampling raw=1, the state register updates on edge DEBOUNCE_CYCLES+3, with raw held high throughout. With DEBOUNCE_CYCLES=4 this is the 7th edge.
- FSM transitions, evaluated each cycle on the press pulses:
  - STOP: clear press -> CLEAR. Otherwise run press -> RUN. Otherwise stay. A simultaneous run+clear press resolves to CLEAR.
  - RUN: run press -> STOP. Clear press is ignored.
  - CLEAR: unconditionally -> STOP after exactly 1 cycle. Any press in this cycle is dropped; mode presses are exempt (see change below).
  - Illegal encoding 11 -> STOP on the next edge.
- Outputs, Moore decode of the state register (no extra latency):
  - enable = (state==RUN).
  - clear = (state==CLEAR). This guarantees clear is never high while enable is high, as the counter datapath requires.
- change is a registered copy of the mode press. It is 1 cycle wide, issued in every FSM state, independent of the FSM, and 1 cycle after the mode press pulse.
- Simultaneous presses on different buttons in the same cycle are each handled as above; run/clear priority follows the FSM table.
- Channels are independent; there is no cross-button lockout.

Test Plan:
1. Reset, then hold btn_run_stop=1 for 20 cycles (DEBOUNCE_CYCLES=4) -> enable rises on the 7th edge after first sample, state=01. Release, then press again -> enable=0, state=00.
2. In STOP, press btn_clear -> clear=1 for exactly 1 cycle, state 00->10->00, enable stays 0. In RUN, press btn_clear -> clear stays 0, state stays 01.
3. Bounce: btn_run_stop toggles 1,0,1,0 every 2 cycles, then stays 0 -> no press, state stays 00. Then hold 1 for 100 cycles -> exactly one transition to RUN.
4. btn_mode pressed 3 times (each held 10 cycles, released 10 cycles) across STOP and RUN -> exactly 3 single-cycle change pulses; FSM state unaffected.
5. Assert run and clear raws on the same cycle from STOP -> press pulses coincide, state goes to CLEAR then STOP, enable never asserts.
6. Assert reset while in RUN with btn_mode mid-debounce -> next cycle enable=0, state=00, change=0, and no change pulse follows.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - button sync/debounce front-end and run/stop/clear sequencer
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_run_stop,
    input  logic       btn_clear,
    input  logic       btn_mode,
    output logic       enable,
    output logic       clear,
    output logic       change,
    output logic [1:0] state
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10
    } state_t;

    state_t        state_q;
    logic [2:0]    raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    stable;
    logic [2:0]    stable_d;
    logic [2:0]    press;
    logic [CW-1:0] cnt [3];

    // channel index: 0 run/stop, 1 clear, 2 mode
    assign raw = {btn_mode, btn_clear, btn_run_stop};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = stable & ~stable_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_STOP;
            change  <= 1'b0;
        end else begin
            change <= press[2];
            case (state_q)
                ST_STOP: begin
                    if (press[1]) begin
                        state_q <= ST_CLEAR;
                    end else if (press[0]) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (press[0]) begin
                        state_q <= ST_STOP;
                    end
                end
                default: state_q <= ST_STOP;
            endcase
        end
    end

    // Moore decode keeps clear and enable mutually exclusive by construction
    assign enable = (state_q == ST_RUN);
    assign clear  = (state_q == ST_CLEAR);
    assign state  = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl with a reference model
module tb_stopwatch_ctrl;

    localparam int D = 4;

    logic       clk;
    logic       reset;
    logic       btn_run_stop;
    logic       btn_clear;
    logic       btn_mode;
    logic       enable;
    logic       clear;
    logic       change;
    logic [1:0] state;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_run_stop (btn_run_stop),
        .btn_clear    (btn_clear),
        .btn_mode     (btn_mode),
        .enable       (enable),
        .clear        (clear),
        .change       (change),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] st;
    } sev_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   started = 0;

    int   chg_q [$];
    sev_t st_q [$];

    // reference model: raw sample history per button, debounced level, pending press
    bit         hist [3][$];
    bit [2:0]   m_stable;
    bit [2:0]   m_press;
    logic [1:0] m_state = 2'b00;
    logic [1:0] mon_prev = 2'b00;

    task automatic model_step(input bit rst, input bit [2:0] r);
        logic [1:0] nxt;
        bit         exp_chg;
        bit [2:0]   np;
        cyc++;
        np = '0;
        if (rst) begin
            for (int b = 0; b < 3; b++) begin
                hist[b].delete();
                for (int k = 0; k < D + 2; k++) hist[b].push_back(1'b0);
            end
            m_stable = '0;
            nxt      = 2'b00;
            exp_chg  = 1'b0;
        end else begin
            exp_chg = m_press[2];
            case (m_state)
                2'b00:   nxt = m_press[1] ? 2'b10 : (m_press[0] ? 2'b01 : 2'b00);
                2'b01:   nxt = m_press[0] ? 2'b00 : 2'b01;
                default: nxt = 2'b00;
            endcase
            for (int b = 0; b < 3; b++) begin
                int n;
                bit v;
                bit ok;
                hist[b].push_back(r[b]);
                if (hist[b].size() > D + 2) void'(hist[b].pop_front());
                n  = hist[b].size();
                // level seen through the 2-stage synchroniser lags the raw sample by two edges
                v  = hist[b][n-3];
                ok = (v != m_stable[b]);
                for (int k = 0; k < D; k++) if (hist[b][n-3-k] != v) ok = 0;
                if (ok) begin
                    m_stable[b] = v;
                    np[b] = v;
                end
            end
        end
        m_press = np;
        if (nxt != m_state) st_q.push_back('{cyc: cyc, st: nxt});
        m_state = nxt;
        if (exp_chg) chg_q.push_back(cyc);
    endtask

    task automatic tick(input bit rst, input bit [2:0] r);
        @(negedge clk);
        reset        = rst;
        btn_run_stop = r[0];
        btn_clear    = r[1];
        btn_mode     = r[2];
        @(posedge clk);
        model_step(rst, r);
        started = 1;
    endtask

    task automatic hold(input bit [2:0] r, input int n);
        repeat (n) tick(1'b0, r);
    endtask

    always @(negedge clk) begin
        if (started) begin
            while (chg_q.size() > 0 && chg_q[0] < cyc) begin
                checks++; errors++;
                $display("FAIL change_missed: actual none, required pulse at cycle %0d", chg_q[0]);
                void'(chg_q.pop_front());
            end
            if (change) begin
                checks++;
                if (chg_q.size() > 0 && chg_q[0] == cyc) begin
                    void'(chg_q.pop_front());
                end else begin
                    errors++;
                    $display("FAIL change_pulse: actual pulse at cycle %0d, required none", cyc);
                end
            end
            while (st_q.size() > 0 && st_q[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL state_missed: actual %b, required %b at cycle %0d", state, st_q[0].st, st_q[0].cyc);
                void'(st_q.pop_front());
            end
            if (state !== mon_prev) begin
                checks++;
                if (st_q.size() > 0 && st_q[0].cyc == cyc && st_q[0].st === state) begin
                    void'(st_q.pop_front());
                end else begin
                    errors++;
                    $display("FAIL state_change: actual %b at cycle %0d, required %b", state, cyc, mon_prev);
                end
                mon_prev = state;
            end
            checks++;
            if (enable !== (m_state == 2'b01) || clear !== (m_state == 2'b10)) begin
                errors++;
                $display("FAIL outputs: actual enable=%b clear=%b, required enable=%b clear=%b at cycle %0d",
                         enable, clear, m_state == 2'b01, m_state == 2'b10, cyc);
            end
        end
    end

    initial begin
        int       rem [3];
        bit [2:0] lvl;
        reset = 1'b1;
        btn_run_stop = 1'b0;
        btn_clear = 1'b0;
        btn_mode = 1'b0;
        repeat (3) tick(1'b1, 3'b000);
        #1;
        checks++;
        if (state !== 2'b00 || enable !== 1'b0 || clear !== 1'b0 || change !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: actual st=%b en=%b clr=%b chg=%b, required all 0",
                     state, enable, clear, change);
        end

        // run/stop toggle
        hold(3'b001, 20); hold(3'b000, 10);
        hold(3'b001, 10); hold(3'b000, 10);
        // clear in STOP, ignored in RUN
        hold(3'b010, 10); hold(3'b000, 10);
        hold(3'b001, 10); hold(3'b000, 10);
        hold(3'b010, 10); hold(3'b000, 10);
        hold(3'b001, 10); hold(3'b000, 10);
        // bounce then long hold
        repeat (2) begin hold(3'b001, 2); hold(3'b000, 2); end
        hold(3'b000, 10); hold(3'b001, 100); hold(3'b000, 10);
        hold(3'b001, 10); hold(3'b000, 10);
        // mode presses across STOP and RUN
        hold(3'b100, 10); hold(3'b000, 10);
        hold(3'b001, 10); hold(3'b000, 10);
        hold(3'b100, 10); hold(3'b000, 10);
        hold(3'b100, 10); hold(3'b000, 10);
        hold(3'b001, 10); hold(3'b000, 10);
        // simultaneous run + clear from STOP
        hold(3'b011, 10); hold(3'b000, 10);
        // reset in RUN with mode mid-debounce
        hold(3'b001, 10); hold(3'b000, 10);
        hold(3'b100, 4);
        tick(1'b1, 3'b100);
        hold(3'b000, 15);
        // button held through reset counts once afterwards
        hold(3'b001, 3); tick(1'b1, 3'b001); hold(3'b001, 12); hold(3'b000, 10);

        for (int b = 0; b < 3; b++) rem[b] = 0;
        lvl = '0;
        repeat (3000) begin
            for (int b = 0; b < 3; b++) begin
                if (rem[b] == 0) begin
                    lvl[b] = 1'($urandom_range(0, 1));
                    rem[b] = $urandom_range(1, 14);
                end
                rem[b]--;
            end
            tick($urandom_range(0, 299) == 0, lvl);
        end

        hold(3'b000, 20);
        @(negedge clk);
        #1;
        checks++;
        if (chg_q.size() != 0 || st_q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual %0d change and %0d state events pending, required 0",
                     chg_q.size(), st_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
